// File: rtl/led_scan_ram.sv
// led_scan_ram: DATA_W x 2**ADDR_W register-file RAM with a registered read port and an LED scan sequencer.
// Optional macro LED_SCAN_RAM_WRITE_THROUGH_EN selects write-through on read-during-write (default is read-first).
module led_scan_ram #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2,
  parameter int SCAN_DIV = 12000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  input  logic              scan_en,
  output logic [DATA_W-1:0] q_led,
  output logic [ADDR_W-1:0] addr_led,
  output logic              scan_wrap,
  output logic              clk_led,
  output logic [DATA_W-1:0] d_led
);

  localparam int unsigned        DEPTH    = 2**ADDR_W;
  localparam int                 CNT_W    = $clog2(SCAN_DIV + 1);
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0]  PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {MANUAL, SCAN} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] scan_ptr_q;
  logic [CNT_W-1:0]  div_cnt_q;
  logic [DATA_W-1:0] q_led_q;
  logic [ADDR_W-1:0] addr_led_q;
  logic              scan_wrap_q;

  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_addr_d = (state_q == SCAN) ? scan_ptr_q : addr;
`ifdef LED_SCAN_RAM_WRITE_THROUGH_EN
    rd_data_d = (we && (addr == rd_addr_d)) ? d : mem_q[rd_addr_d];
`else
    rd_data_d = mem_q[rd_addr_d];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q     <= MANUAL;
      scan_ptr_q  <= '0;
      div_cnt_q   <= '0;
      q_led_q     <= '0;
      addr_led_q  <= '0;
      scan_wrap_q <= 1'b0;
    end else begin
      if (we) begin
        mem_q[addr] <= d;
      end
      q_led_q     <= rd_data_d;
      addr_led_q  <= rd_addr_d;
      scan_wrap_q <= 1'b0;
      case (state_q)
        MANUAL: begin
          if (scan_en) begin
            state_q    <= SCAN;
            scan_ptr_q <= '0;
            div_cnt_q  <= '0;
          end
        end
        SCAN: begin
          // Leaving scan takes priority over a step due on the same edge.
          if (!scan_en) begin
            state_q    <= MANUAL;
            scan_ptr_q <= '0;
            div_cnt_q  <= '0;
          end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q   <= '0;
            scan_ptr_q  <= scan_ptr_q + 1'b1;
            scan_wrap_q <= (scan_ptr_q == PTR_LAST);
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: state_q <= MANUAL;
      endcase
    end
  end

  assign q_led     = q_led_q;
  assign addr_led  = addr_led_q;
  assign scan_wrap = scan_wrap_q;
  assign clk_led   = clk;
  assign d_led     = d;

endmodule

// File: doc/led_scan_ram.md
Name: led_scan_ram

Overview:
- Parametrised DATA_W x 2**ADDR_W register-file RAM for board LED demos.
- Replaces the decoded-clock 4x1-bit DFF RAM with a single-clock design:
  - synchronous write enable;
  - registered read port;
  - built-in scan sequencer that steps through every word and drives it onto the LEDs at a divided rate.
- Sits directly between board switches/buttons and LEDs.

Parameters:
- DATA_W, 4: bits per word.
- ADDR_W, 2: address bits; DEPTH = 2**ADDR_W words.
- SCAN_DIV, 12000000: clk cycles per scan step, minimum 1. Divider counter width is $clog2(SCAN_DIV+1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  manual read/write address.
- d  in  DATA_W  write data.
- we  in  1  write enable; sampled on the clk edge.
- scan_en  in  1  1 = scan mode, 0 = manual mode.
- q_led  out  DATA_W  registered read data.
- addr_led  out  ADDR_W  registered address that q_led belongs to.
- scan_wrap  out  1  one-cycle pulse when the scan pointer wraps to 0.
- clk_led  out  1  combinational copy of clk.
- d_led  out  DATA_W  combinational copy of d.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - all DEPTH words cleared to 0;
  - q_led=0, addr_led=0, scan_wrap=0;
  - state=MANUAL, scan_ptr=0, div_cnt=0.
  - Reset deasserted: first active edge is the next clk rise.
- Write:
  - on a rising edge with we=1, mem[addr] <= d.
  - Writes use addr in both modes and are never blocked by scan.
- Read address: rd_addr = (state==SCAN) ? scan_ptr : addr.
- Read latency: 1 cycle. Every edge, q_led <= mem[rd_addr] and addr_led <= rd_addr.
- Read-during-write to the same word (default): q_led gets the OLD contents (read-first).
- State machine, 2 states:
  - MANUAL -> SCAN when scan_en=1 on an edge. On entry: scan_ptr=0, div_cnt=0.
  - SCAN -> MANUAL when scan_en=0 on an edge. scan_ptr and div_cnt are reset to 0.
  - Re-entering SCAN always starts at word 0.
- In SCAN:
  - div_cnt increments each cycle.
  - When div_cnt==SCAN_DIV-1: div_cnt <= 0 and scan_ptr <= scan_ptr+1, wrapping modulo DEPTH.
  - On the step where scan_ptr goes DEPTH-1 -> 0, scan_wrap=1 for exactly that one cycle (registered, same edge as the pointer update).
  - SCAN_DIV=1: scan_ptr advances every cycle.
- scan_wrap is 0 at all times in MANUAL.
- scan_en falling on the same edge as a pending step: the mode change wins; no step, no wrap pulse.
- Address arithmetic is unsigned ADDR_W bits. No out-of-range addresses exist.

Optional Feature:
- Macro: LED_SCAN_RAM_WRITE_THROUGH_EN.
- Defined: read-during-write to the same word (we=1, addr==rd_addr) sets q_led <= d (new data, write-through bypass). Applies in both modes.
- Undefined: read-first; q_led gets the old word. No other behaviour changes.

Test Plan (DATA_W=4, ADDR_W=2, SCAN_DIV=4):
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle after writing mem[2]=4'hA.
  - Required: q_led=0 and addr_led=0 immediately, without waiting for a clk edge. After release, manual read of addr=2 gives q_led=0 one cycle later.
- Manual write/read:
  - Stimulus: write 4'h3,4'h5,4'hC,4'hF to addrs 0..3, then read addr=2 with we=0.
  - Required: q_led=4'hC and addr_led=2 on the cycle after the addr is applied.
- Scan:
  - Stimulus: memory as above; scan_en=1.
  - Required: addr_led steps 0,1,2,3,0 every 4 cycles; q_led follows 3,5,C,F,3. scan_wrap is high for exactly 1 cycle at the 3->0 step and low otherwise.
- Scan exit/restart:
  - Stimulus: drop scan_en while ptr=2; raise it again 3 cycles later.
  - Required: display restarts at addr_led=0 and q_led=4'h3. No wrap pulse on exit.
- Read-during-write:
  - Stimulus: mem[1]=4'h5; manual addr=1, we=1, d=4'h9.
  - Required: next cycle q_led=4'h5 (macro undefined) or 4'h9 (macro defined). The following cycle q_led=4'h9 in both builds.
- Reset mid-scan:
  - Stimulus: rst_n low for 2 cycles while ptr=3 and div_cnt=2.
  - Required: after release with scan_en still 1, FSM starts in MANUAL. It enters SCAN on the first edge, first step occurs 4 cycles later, all words read as 0.
